// File: rtl/fix_table_arbiter.sv
// fix_table_arbiter
// Shares the single port of a 256 x 16 coefficient table RAM between two
// datapath read requesters and one host write/reload port, and counts the
// cycles in which requesters contend.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   r0_* / r1_*                  read requesters: valid/addr in,
//                                ready/rvalid/rdata out
//   w_*                          host write: valid/addr/data/byteenable in,
//                                ready out
//   mem_*                        RAM port; the issue signals are
//                                combinational, mem_readdata is the RAM q
//   cnt_clr, conflict_cnt        clear and value of the contention counter
//
// Ready and the mem_* issue signals are combinational from the valids and
// the arbiter state, so an access is issued in the cycle it is granted.
// Read data comes back registered two cycles after acceptance.

module fix_table_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned BE_W     = 2,
    parameter int unsigned WR_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              r0_valid,
    input  logic [ADDR_W-1:0] r0_addr,
    output logic              r0_ready,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,

    input  logic              r1_valid,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r1_ready,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,

    input  logic              w_valid,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [BE_W-1:0]   w_byteenable,
    output logic              w_ready,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_debugaccess,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,

    input  logic              cnt_clr,
    output logic [15:0]       conflict_cnt
);

    localparam int unsigned RUN_W = 3;
    localparam int unsigned CNT_W = 16;

    localparam logic [RUN_W-1:0] WR_BURST_C = RUN_W'(WR_BURST);
    localparam logic [RUN_W-1:0] RUN_MAX    = {RUN_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    // run: low through reset and for the first cycle after release
    logic              r_run;

    // arbiter state
    logic              r_last_rd;     // port of the most recent read grant
    logic [RUN_W-1:0]  r_wr_run;      // consecutive write grants

    // response pipeline
    logic              r_rd_issued;   // stage 1: a read was issued last cycle
    logic              r_rd_port;     // stage 1: which port issued it
    logic              r_r0_rvalid;
    logic              r_r1_rvalid;
    logic [DATA_W-1:0] r_r0_rdata;
    logic [DATA_W-1:0] r_r1_rdata;

    logic [CNT_W-1:0]  r_conflict_cnt;

    // combinational arbitration
    logic              w_rd_pend;
    logic              w_wr_mask;
    logic              w_gnt_w;
    logic              w_gnt_r0;
    logic              w_gnt_r1;
    logic              w_gnt_rd;
    logic              w_contend;

    // Run flop: sets on the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Grant selection: write first, unless a long write run is starving a
    // pending read; reads alternate when both are pending.
    always_comb begin
        w_rd_pend = r0_valid | r1_valid;
        w_wr_mask = (r_wr_run >= WR_BURST_C) && w_rd_pend;
        w_gnt_w   = r_run && w_valid && !w_wr_mask;
        w_gnt_r0  = 1'b0;
        w_gnt_r1  = 1'b0;
        if (r_run && !w_gnt_w && w_rd_pend) begin
            if (r0_valid && r1_valid) begin
                // the port that did not win last time goes now
                if (r_last_rd) begin
                    w_gnt_r0 = 1'b1;
                end else begin
                    w_gnt_r1 = 1'b1;
                end
            end else if (r0_valid) begin
                w_gnt_r0 = 1'b1;
            end else begin
                w_gnt_r1 = 1'b1;
            end
        end
        w_gnt_rd = w_gnt_r0 | w_gnt_r1;
    end

    assign w_ready  = w_gnt_w;
    assign r0_ready = w_gnt_r0;
    assign r1_ready = w_gnt_r1;

    // RAM issue mux, driven in the grant cycle.
    always_comb begin
        mem_address     = '0;
        mem_chipselect  = 1'b0;
        mem_write       = 1'b0;
        mem_debugaccess = 1'b0;
        mem_byteenable  = '0;
        mem_writedata   = '0;
        if (w_gnt_w) begin
            mem_address     = w_addr;
            mem_chipselect  = 1'b1;
            mem_write       = 1'b1;
            mem_debugaccess = 1'b1;
            mem_byteenable  = w_byteenable;
            mem_writedata   = w_data;
        end else if (w_gnt_r0) begin
            mem_address     = r0_addr;
            mem_chipselect  = 1'b1;
            mem_byteenable  = {BE_W{1'b1}};
        end else if (w_gnt_r1) begin
            mem_address     = r1_addr;
            mem_chipselect  = 1'b1;
            mem_byteenable  = {BE_W{1'b1}};
        end
    end

    assign mem_clken = r_run;

    // Read round-robin pointer and write-run counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_rd <= 1'b1;
            r_wr_run  <= '0;
        end else begin
            if (w_gnt_r0) begin
                r_last_rd <= 1'b0;
            end else if (w_gnt_r1) begin
                r_last_rd <= 1'b1;
            end

            // saturate so an unopposed write stream cannot wrap the count
            if (w_gnt_rd || !w_valid) begin
                r_wr_run <= '0;
            end else if (w_gnt_w && (r_wr_run != RUN_MAX)) begin
                r_wr_run <= r_wr_run + RUN_W'(1);
            end
        end
    end

    // Stage 1 remembers the issuing port while the RAM produces q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_issued <= 1'b0;
            r_rd_port   <= 1'b0;
        end else begin
            r_rd_issued <= w_gnt_rd;
            r_rd_port   <= w_gnt_r1;
        end
    end

    // Stage 2 routes q to the issuing port; the other port keeps its data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_r0_rvalid <= 1'b0;
            r_r1_rvalid <= 1'b0;
            r_r0_rdata  <= '0;
            r_r1_rdata  <= '0;
        end else begin
            r_r0_rvalid <= r_rd_issued && !r_rd_port;
            r_r1_rvalid <= r_rd_issued && r_rd_port;
            if (r_rd_issued && !r_rd_port) begin
                r_r0_rdata <= mem_readdata;
            end
            if (r_rd_issued && r_rd_port) begin
                r_r1_rdata <= mem_readdata;
            end
        end
    end

    assign r0_rvalid = r_r0_rvalid;
    assign r1_rvalid = r_r1_rvalid;
    assign r0_rdata  = r_r0_rdata;
    assign r1_rdata  = r_r1_rdata;

    // Contention: any two of the three request valids at once.
    assign w_contend = (r0_valid & r1_valid) | (r0_valid & w_valid) |
                       (r1_valid & w_valid);

    // Saturating contention counter; clear has priority over increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_conflict_cnt <= '0;
        end else if (cnt_clr) begin
            r_conflict_cnt <= '0;
        end else if (r_run && w_contend && (r_conflict_cnt != CNT_MAX)) begin
            r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
        end
    end

    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_fix_table_arbiter.sv
// Bench for fix_table_arbiter: behavioural RAM on the mem_* port, a shadow
// copy of the table maintained from accepted host writes, a response
// scoreboard, a per-cycle vector table and directed corner sequences.

module tb_fix_table_arbiter;

    logic        clk;
    logic        reset_n;
    logic        r0_valid, r1_valid, w_valid;
    logic [7:0]  r0_addr, r1_addr, w_addr;
    logic        r0_ready, r1_ready, w_ready;
    logic        r0_rvalid, r1_rvalid;
    logic [15:0] r0_rdata, r1_rdata;
    logic [15:0] w_data;
    logic [1:0]  w_byteenable;
    logic [7:0]  mem_address;
    logic        mem_chipselect, mem_write, mem_debugaccess, mem_clken;
    logic [1:0]  mem_byteenable;
    logic [15:0] mem_writedata;
    logic [15:0] mem_readdata;
    logic        cnt_clr;
    logic [15:0] conflict_cnt;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned cyc     = 0;

    fix_table_arbiter #(
        .ADDR_W(8), .DATA_W(16), .BE_W(2), .WR_BURST(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_ready(r0_ready),
        .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_ready(r1_ready),
        .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data),
        .w_byteenable(w_byteenable), .w_ready(w_ready),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_debugaccess(mem_debugaccess),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .cnt_clr(cnt_clr), .conflict_cnt(conflict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Power-on table contents, known to both the RAM and the shadow.
    function automatic logic [15:0] init_val(input logic [7:0] a);
        return {a ^ 8'h5A, a};
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = d[7:0];
        if (be[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    // Behavioural single-port RAM: writes need debugaccess, q is registered.
    bit [15:0] ram [256];
    bit        ram_wr [256];
    logic [15:0] ram_q = 16'h0;

    function automatic logic [15:0] ram_rd(input logic [7:0] a);
        return ram_wr[a] ? ram[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write && mem_debugaccess) begin
                ram[mem_address]    <= merge(ram_rd(mem_address), mem_writedata, mem_byteenable);
                ram_wr[mem_address] <= 1'b1;
            end else if (!mem_write) begin
                ram_q <= ram_rd(mem_address);
            end
        end
    end
    assign mem_readdata = ram_q;

    // Shadow table, updated from accepted host writes only.
    bit [15:0] sh [256];
    bit        sh_wr [256];

    function automatic logic [15:0] sh_rd(input logic [7:0] a);
        return sh_wr[a] ? sh[a] : init_val(a);
    endfunction

    typedef struct {
        logic        port;
        logic [15:0] data;
        int unsigned acc_cyc;
    } exp_t;

    exp_t sbq[$];

    task automatic pop_check(input logic port, input logic [15:0] data);
        exp_t e;
        if (sbq.size() == 0) begin
            n_total++;
            $display("FAIL rvalid_unexpected: got rvalid on port %0d with no read outstanding (cycle %0d)",
                     port, cyc);
        end else begin
            e = sbq.pop_front();
            chk("resp_port", 32'(port), 32'(e.port));
            chk("resp_data", 32'(data), 32'(e.data));
            chk("resp_latency", cyc, e.acc_cyc + 2);
        end
    endtask

    // Scoreboard monitor: record accepts, check responses.
    always @(negedge clk) begin
        chk("one_ready", 32'($countones({r0_ready, r1_ready, w_ready}) <= 1), 32'd1);
        if (r0_rvalid && r1_rvalid) begin
            n_total++;
            $display("FAIL both_rvalid: got both rvalids high, expected at most one (cycle %0d)", cyc);
        end
        if (r0_rvalid) pop_check(1'b0, r0_rdata);
        if (r1_rvalid) pop_check(1'b1, r1_rdata);
        if (r0_valid && r0_ready) sbq.push_back('{port: 1'b0, data: sh_rd(r0_addr), acc_cyc: cyc});
        if (r1_valid && r1_ready) sbq.push_back('{port: 1'b1, data: sh_rd(r1_addr), acc_cyc: cyc});
        if (w_valid && w_ready) begin
            sh[w_addr]    <= merge(sh_rd(w_addr), w_data, w_byteenable);
            sh_wr[w_addr] <= 1'b1;
        end
    end

    // One vector = one cycle of inputs and the expected grant/counter.
    typedef struct {
        logic        wv;
        logic [7:0]  wa;
        logic [15:0] wd;
        logic [1:0]  wbe;
        logic        r0v;
        logic [7:0]  r0a;
        logic        r1v;
        logic [7:0]  r1a;
        logic [2:0]  exp_rdy;   // {w, r1, r0}
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic wv, input logic [7:0] wa, input logic [15:0] wd,
                        input logic [1:0] wbe, input logic r0v, input logic [7:0] r0a,
                        input logic r1v, input logic [7:0] r1a, input logic [2:0] rdy,
                        input logic [15:0] cnt);
        vq.push_back('{wv: wv, wa: wa, wd: wd, wbe: wbe, r0v: r0v, r0a: r0a,
                       r1v: r1v, r1a: r1a, exp_rdy: rdy, exp_cnt: cnt});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  ea;
        logic [2:0]  rdy;

        // two reads contending: strict alternation starting at r0
        addv(0, 8'h00, 16'h0000, 2'b11, 1, 8'h30, 1, 8'h40, 3'b001, 16'd0);
        addv(0, 8'h00, 16'h0000, 2'b11, 1, 8'h31, 1, 8'h40, 3'b010, 16'd1);
        addv(0, 8'h00, 16'h0000, 2'b11, 1, 8'h31, 1, 8'h41, 3'b001, 16'd2);
        addv(0, 8'h00, 16'h0000, 2'b11, 1, 8'h32, 1, 8'h41, 3'b010, 16'd3);
        addv(0, 8'h00, 16'h0000, 2'b11, 1, 8'h32, 1, 8'h42, 3'b001, 16'd4);
        addv(0, 8'h00, 16'h0000, 2'b11, 1, 8'h33, 1, 8'h42, 3'b010, 16'd5);
        addv(0, 8'h00, 16'h0000, 2'b11, 0, 8'h00, 0, 8'h00, 3'b000, 16'd6);
        // all three valid: four writes, then one read, r0 then r1
        addv(1, 8'h70, 16'hC000, 2'b11, 1, 8'h50, 1, 8'h60, 3'b100, 16'd6);
        addv(1, 8'h71, 16'hC001, 2'b11, 1, 8'h50, 1, 8'h60, 3'b100, 16'd7);
        addv(1, 8'h72, 16'hC002, 2'b11, 1, 8'h50, 1, 8'h60, 3'b100, 16'd8);
        addv(1, 8'h73, 16'hC003, 2'b11, 1, 8'h50, 1, 8'h60, 3'b100, 16'd9);
        addv(1, 8'h74, 16'hC004, 2'b11, 1, 8'h50, 1, 8'h60, 3'b001, 16'd10);
        addv(1, 8'h74, 16'hC004, 2'b11, 1, 8'h51, 1, 8'h60, 3'b100, 16'd11);
        addv(1, 8'h75, 16'hC005, 2'b11, 1, 8'h51, 1, 8'h60, 3'b100, 16'd12);
        addv(1, 8'h76, 16'hC006, 2'b11, 1, 8'h51, 1, 8'h60, 3'b100, 16'd13);
        addv(1, 8'h77, 16'hC007, 2'b11, 1, 8'h51, 1, 8'h60, 3'b100, 16'd14);
        addv(1, 8'h78, 16'hC008, 2'b11, 1, 8'h51, 1, 8'h60, 3'b010, 16'd15);
        addv(1, 8'h78, 16'hC008, 2'b11, 1, 8'h51, 1, 8'h61, 3'b100, 16'd16);
        addv(1, 8'h79, 16'hC009, 2'b11, 1, 8'h51, 1, 8'h61, 3'b100, 16'd17);
        addv(0, 8'h00, 16'h0000, 2'b11, 0, 8'h00, 0, 8'h00, 3'b000, 16'd18);
        // unopposed write stream runs past the burst limit and saturates wr_run
        for (int k = 0; k < 8; k++) begin
            addv(1, 8'(8'h80 + k), 16'(16'hD000 + k), 2'b11, 0, 8'h00, 0, 8'h00, 3'b100, 16'd18);
        end
        addv(1, 8'h88, 16'hD008, 2'b11, 1, 8'h83, 0, 8'h00, 3'b001, 16'd18);
        addv(0, 8'h00, 16'h0000, 2'b11, 0, 8'h00, 1, 8'h85, 3'b010, 16'd19);
        addv(1, 8'h88, 16'hD008, 2'b10, 0, 8'h00, 0, 8'h00, 3'b100, 16'd19);
        addv(0, 8'h00, 16'h0000, 2'b11, 1, 8'h88, 0, 8'h00, 3'b001, 16'd19);
        addv(0, 8'h00, 16'h0000, 2'b11, 0, 8'h00, 0, 8'h00, 3'b000, 16'd19);

        // reset with r0 already requesting
        reset_n = 1'b0; cnt_clr = 1'b0;
        w_valid = 1'b0; w_addr = 8'h00; w_data = 16'h0000; w_byteenable = 2'b00;
        r0_valid = 1'b1; r0_addr = 8'h10; r1_valid = 1'b0; r1_addr = 8'h00;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_r0_ready", 32'(r0_ready), 32'd0);
        chk("rst_clken", 32'(mem_clken), 32'd0);
        chk("rst_cs", 32'(mem_chipselect), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_rvalid", 32'({r0_rvalid, r1_rvalid}), 32'd0);
        chk("rst_rdata", 32'(r0_rdata), 32'd0);
        chk("rst_cnt", 32'(conflict_cnt), 32'd0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("first_cycle_ready", 32'(r0_ready), 32'd0);
        chk("first_cycle_clken", 32'(mem_clken), 32'd0);
        tick();
        @(negedge clk);
        chk("a_r0_ready", 32'(r0_ready), 32'd1);
        chk("a_addr", 32'(mem_address), 32'h10);
        chk("a_cs", 32'(mem_chipselect), 32'd1);
        chk("a_write", 32'(mem_write), 32'd0);
        chk("a_be", 32'(mem_byteenable), 32'h3);
        chk("a_clken", 32'(mem_clken), 32'd1);
        tick();
        r0_valid = 1'b0;
        @(negedge clk);
        chk("a_rvalid_n1", 32'(r0_rvalid), 32'd0);
        tick();
        @(negedge clk);
        chk("a_rvalid_n2", 32'(r0_rvalid), 32'd1);
        chk("a_rdata", 32'(r0_rdata), 32'(init_val(8'h10)));

        // full write then read-back of the same word on r1
        tick();
        w_valid = 1'b1; w_addr = 8'h05; w_data = 16'h1234; w_byteenable = 2'b11;
        @(negedge clk);
        chk("b_w_ready", 32'(w_ready), 32'd1);
        chk("b_write", 32'(mem_write), 32'd1);
        chk("b_dbg", 32'(mem_debugaccess), 32'd1);
        chk("b_wdata", 32'(mem_writedata), 32'h1234);
        chk("b_addr", 32'(mem_address), 32'h05);
        tick();
        w_valid = 1'b0; r1_valid = 1'b1; r1_addr = 8'h05;
        @(negedge clk);
        chk("b_r1_ready", 32'(r1_ready), 32'd1);
        chk("b_dbg_rd", 32'(mem_debugaccess), 32'd0);
        tick();
        r1_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("b_r1_rvalid", 32'(r1_rvalid), 32'd1);
        chk("b_r1_rdata", 32'(r1_rdata), 32'h1234);

        // partial write of the low byte, read back on r0
        tick();
        w_valid = 1'b1; w_data = 16'hABCD; w_byteenable = 2'b01;
        @(negedge clk);
        chk("c_be", 32'(mem_byteenable), 32'h1);
        tick();
        w_valid = 1'b0; r0_valid = 1'b1; r0_addr = 8'h05;
        @(negedge clk);
        chk("c_r0_ready", 32'(r0_ready), 32'd1);
        tick();
        r0_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("c_r0_rvalid", 32'(r0_rvalid), 32'd1);
        chk("c_r0_rdata", 32'(r0_rdata), 32'h12CD);
        chk("c_r1_rdata_kept", 32'(r1_rdata), 32'h1234);

        // reset while a read is in flight: its response must vanish
        tick();
        r0_valid = 1'b1; r0_addr = 8'h20;
        @(negedge clk);
        chk("d_r0_ready", 32'(r0_ready), 32'd1);
        tick();
        r0_valid = 1'b0; reset_n = 1'b0;
        sbq.delete();
        @(negedge clk);
        chk("d_rvalid_n1", 32'({r0_rvalid, r1_rvalid}), 32'd0);
        tick();
        @(negedge clk);
        chk("d_rvalid_n2", 32'({r0_rvalid, r1_rvalid}), 32'd0);
        chk("d_clken", 32'(mem_clken), 32'd0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("d_rvalid_n3", 32'({r0_rvalid, r1_rvalid}), 32'd0);
        chk("d_cnt", 32'(conflict_cnt), 32'd0);

        // vector table, one cycle each
        for (int i = 0; i < vq.size(); i++) begin
            tick();
            w_valid = vq[i].wv; w_addr = vq[i].wa; w_data = vq[i].wd;
            w_byteenable = vq[i].wbe;
            r0_valid = vq[i].r0v; r0_addr = vq[i].r0a;
            r1_valid = vq[i].r1v; r1_addr = vq[i].r1a;
            @(negedge clk);
            rdy = vq[i].exp_rdy;
            ea  = rdy[2] ? vq[i].wa : rdy[0] ? vq[i].r0a : rdy[1] ? vq[i].r1a : 8'h00;
            chk($sformatf("v%0d_ready", i), 32'({w_ready, r1_ready, r0_ready}), 32'(rdy));
            chk($sformatf("v%0d_cnt", i), 32'(conflict_cnt), 32'(vq[i].exp_cnt));
            chk($sformatf("v%0d_cs", i), 32'(mem_chipselect), 32'(|rdy));
            chk($sformatf("v%0d_write", i), 32'(mem_write), 32'(rdy[2]));
            chk($sformatf("v%0d_addr", i), 32'(mem_address), 32'(ea));
        end
        tick();
        w_valid = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;

        // counter saturation and clear-beats-increment
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        r0_valid = 1'b1; r0_addr = 8'h01; r1_valid = 1'b1; r1_addr = 8'h02;
        @(negedge clk);
        chk("e_cnt_cleared", 32'(conflict_cnt), 32'd0);
        repeat (16'hFFFE) @(posedge clk);
        @(negedge clk);
        chk("e_cnt_fffe", 32'(conflict_cnt), 32'hFFFE);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("e_cnt_sat%0d", k), 32'(conflict_cnt), 32'hFFFF);
        end
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
        @(negedge clk);
        chk("e_clr_wins", 32'(conflict_cnt), 32'd0);

        repeat (4) tick();
        @(negedge clk);
        chk("drain_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fix_table_arbiter.md
# fix_table_arbiter

Arbitration and sequencing controller for the single-port 256 x 16 fixed-point coefficient table RAM in the soc_system. It lets two datapath read requesters and one host write/reload port share the one RAM port. Accesses are issued at up to one per cycle, and registered read data is returned to the requester that issued it. It also keeps a saturating count of cycles in which requesters contended.

## Interface
Parameters:
- ADDR_W, 8, table address width (256 words)
- DATA_W, 16, table word width
- BE_W, 2, byte-enable width (DATA_W/8)
- WR_BURST, 4, maximum consecutive write grants while a read is pending

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- r0_valid  in  1  read request, port 0
- r0_addr  in  ADDR_W  read address, port 0
- r0_ready  out  1  request accepted this cycle, port 0
- r0_rvalid  out  1  r0_rdata valid, one-cycle pulse
- r0_rdata  out  DATA_W  read data, port 0
- r1_valid, r1_addr, r1_ready, r1_rvalid, r1_rdata: same as port 0, for port 1
- w_valid  in  1  write request, host port
- w_addr  in  ADDR_W  write address
- w_data  in  DATA_W  write data
- w_byteenable  in  BE_W  byte lanes to write
- w_ready  out  1  write accepted this cycle
- mem_address  out  ADDR_W  RAM address
- mem_chipselect  out  1  RAM access this cycle
- mem_write  out  1  RAM write strobe
- mem_debugaccess  out  1  equals mem_write; the RAM only writes when this is set
- mem_byteenable  out  BE_W  RAM byte enables; all ones on reads
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable; held at 1 once run=1
- mem_readdata  in  DATA_W  RAM q, valid the cycle after an issued read
- cnt_clr  in  1  synchronous clear of conflict_cnt
- conflict_cnt  out  16  saturating contention counter

## Operation
- Run flop:
  - reset_n low clears run.
  - run sets on the first clk edge after reset_n deasserts.
  - While run=0, every ready, every mem_* strobe and mem_clken is 0.
- Handshake:
  - A request transfers when valid and ready are both high in the same cycle.
  - Ready is combinational from the valids and the arbiter state. At most one ready is high per cycle.
  - Requesters hold valid, addr and data stable until accepted.
- Grant order:
  - The write port wins over both read ports.
  - Exception: if wr_run reaches WR_BURST and any read is pending, the write port is masked for that cycle and a read is granted.
- wr_run:
  - 3-bit count of consecutive write grants.
  - Cleared by any read grant, and by any cycle in which w_valid=0.
- Read round-robin:
  - The last_rd pointer resets to 1, so port 0 wins the first tie.
  - The pointer updates only on read grants.
  - When both reads are pending, the port not equal to last_rd wins.
- Issue (combinational, same cycle as the grant):
  - mem_address takes the granted address and mem_chipselect=1.
  - On a write grant, mem_write=1, mem_debugaccess=1, and mem_byteenable/mem_writedata take the w_* values.
- Response pipeline:
  - Stage-1 flops hold {rd_issued, port_id}.
  - In the next cycle, mem_readdata is registered into the matching rK_rdata and rK_rvalid pulses for one cycle.
  - The non-matching port's rdata keeps its old value.
- Conflict counter:
  - Increments in every run cycle where two or more of r0_valid, r1_valid and w_valid are high.
  - Saturates at 0xFFFF.
  - If cnt_clr and an increment happen in the same cycle, cnt_clr wins and the result is 0.

## Timing
- Reset values: every *_ready, *_rvalid, mem_chipselect, mem_write, mem_debugaccess and mem_clken are 0. rK_rdata, mem_address, mem_writedata, mem_byteenable and conflict_cnt are 0. last_rd=1, wr_run=0, pipeline empty.
- Read latency: a request accepted in cycle N gives rK_rvalid=1 in cycle N+2. Throughput is one access per cycle across all ports.
- Write then read of the same address in consecutive cycles returns the new data (single port, sequential access).
- Write accepted in cycle N: the RAM updates at the end of cycle N.
- Reset asserted mid-operation: in-flight reads are discarded, no rvalid is produced, and the arbiter state returns to its reset values.
- Each rvalid is exactly one cycle wide. There is no backpressure on responses; requesters must accept them.

## Test plan
- Reset release with r0_valid=1, addr 0x10: r0_ready=0 in the first post-reset cycle, then 1. r0_rvalid appears 2 cycles after acceptance, carrying mem_readdata at 0x10.
- Write 0x1234 to 0x05 with byteenable 2'b11, then r1 read of 0x05 in the next cycle: mem_debugaccess=1 during the write, and r1_rdata=0x1234 with r1_rvalid 2 cycles after the read is accepted.
- Write 0xABCD to 0x05 with byteenable 2'b01 over 0x1234, then read 0x05: result is 0x12CD.
- r0 and r1 both valid continuously for 6 cycles: grants go r0, r1, r0, r1, r0, r1, each rvalid returns to the correct port with its own data, and conflict_cnt=6.
- w_valid, r0_valid and r1_valid all held for 12 cycles with WR_BURST=4: 4 writes, then 1 read, repeating. Over the 12 cycles that is 10 writes and 2 reads (r0 then r1), with no read port starved.
- conflict_cnt preloaded to 0xFFFE by 0xFFFE contention cycles, then 3 more contention cycles: the count saturates at 0xFFFF. cnt_clr together with contention in the same cycle gives 0 on the next cycle.
